// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared definitions for the program-counter sequencer and the control unit
//   that drives it. It holds the reset PC value, the command encoding and the
//   fixed command-priority decoder.
//
//   Command priority, highest first:
//     load > call > ret > rel (only when PC_REL_BRANCH_EN is defined) > count
//
//   Reset is not a command. The PC register handles reset before this decoder
//   is consulted.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  // PC value loaded by reset.
  localparam int PC_RESET = 0;

  // Exactly one command takes effect per cycle.
  typedef enum logic [2:0] {
    CMD_HOLD  = 3'd0,
    CMD_COUNT = 3'd1,
    CMD_REL   = 3'd2,
    CMD_RET   = 3'd3,
    CMD_CALL  = 3'd4,
    CMD_LOAD  = 3'd5
  } cmd_e;

  // Fixed-priority decode. Lower-priority requests are dropped for the cycle.
  function automatic cmd_e pick_cmd(input logic load,
                                    input logic call,
                                    input logic ret,
                                    input logic rel,
                                    input logic count);
    cmd_e cmd;
    if (load)       cmd = CMD_LOAD;
    else if (call)  cmd = CMD_CALL;
    else if (ret)   cmd = CMD_RET;
    else if (rel)   cmd = CMD_REL;
    else if (count) cmd = CMD_COUNT;
    else            cmd = CMD_HOLD;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// -----------------------------------------------------------------------------
// pc_return_stack
//   DEPTH-entry LIFO that holds subroutine return addresses. It also reports
//   its fill level, full and empty status, and sticky overflow and underflow
//   flags.
//
//   Ports
//     clk          in   1    rising-edge clock
//     reset        in   1    synchronous, active-high
//     i_push       in   1    push i_push_data (sets overflow instead when full)
//     i_pop        in   1    drop the top entry (sets underflow instead when empty)
//     i_push_data  in   W    return address to store
//     o_top_data   out  W    current top entry (valid only when not empty)
//     o_level      out  SW   number of valid entries
//     o_full       out  1    o_level == DEPTH
//     o_empty      out  1    o_level == 0
//     o_overflow   out  1    sticky, cleared only by reset
//     o_underflow  out  1    sticky, cleared only by reset
//
//   i_push and i_pop are never asserted together. The parent's priority
//   decoder guarantees this.
// -----------------------------------------------------------------------------
module pc_return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_push_data,
  output logic [W-1:0]  o_top_data,
  output logic [SW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [SW-1:0] r_level;
  logic          r_overflow;
  logic          r_underflow;
  logic          w_full;
  logic          w_empty;

  // The status flags come from registered state only, so no command input
  // has a combinational path to them.
  assign w_full  = (r_level == SW'(DEPTH));
  assign w_empty = (r_level == '0);

  // NOTE: the storage array has no reset. Its contents are don't-care until
  // written, and the level counter alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && i_push && !w_full) begin
      r_mem[AW'(r_level)] <= i_push_data;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_push) begin
      if (w_full) r_overflow <= 1'b1;
      else        r_level    <= r_level + SW'(1);
    end else if (i_pop) begin
      if (w_empty) r_underflow <= 1'b1;
      else         r_level     <= r_level - SW'(1);
    end
  end

  // When the stack is empty this index wraps. The parent ignores the value
  // in that case.
  assign o_top_data  = r_mem[AW'(r_level - SW'(1))];
  assign o_level     = r_level;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   W-bit program counter. It supports increment, absolute jump, and
//   subroutine call/return through a DEPTH-entry return-address stack. It sits
//   between the control unit and the memory address register. It drives the
//   shared address bus (tri-state) and an always-driven private copy.
//
//   Optional feature: define PC_REL_BRANCH_EN to add relative branching.
//   This adds the ports rel_en and rel_offset. rel_offset is two's
//   complement, and PC becomes PC + rel_offset mod 2^W. This command sits
//   below ret_en and above count_en.
//
//   Ports
//     clk          in   1    rising-edge clock
//     reset        in   1    synchronous, active-high, overrides everything
//     count_en     in   1    PC <= PC + 1
//     load_en      in   1    PC <= load_addr
//     load_addr    in   W    jump / call target
//     call_en      in   1    push PC + 1, PC <= load_addr
//     ret_en       in   1    PC <= popped return address
//     rel_en       in   1    (PC_REL_BRANCH_EN only) PC <= PC + rel_offset
//     rel_offset   in   W    (PC_REL_BRANCH_EN only) signed branch offset
//     out_en       in   1    drive pc_bus
//     pc_bus       out  W    PC when out_en = 1, otherwise high impedance
//     pc_value     out  W    PC, always driven
//     stack_level  out  SW   valid return-stack entries
//     stack_full   out  1    stack_level == DEPTH
//     stack_empty  out  1    stack_level == 0
//     overflow     out  1    sticky: call attempted while full
//     underflow    out  1    sticky: ret attempted while empty
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter  int W     = 4,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          count_en,
  input  logic          load_en,
  input  logic [W-1:0]  load_addr,
  input  logic          call_en,
  input  logic          ret_en,
`ifdef PC_REL_BRANCH_EN
  input  logic          rel_en,
  input  logic [W-1:0]  rel_offset,
`endif
  input  logic          out_en,
  output logic [W-1:0]  pc_bus,
  output logic [W-1:0]  pc_value,
  output logic [SW-1:0] stack_level,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          overflow,
  output logic          underflow
);

  logic [W-1:0] r_pc;
  logic         w_rel_en;
  logic [W-1:0] w_rel_offset;
  cmd_e         w_cmd;
  logic [W-1:0] w_top;
  logic         w_full;
  logic         w_empty;

`ifdef PC_REL_BRANCH_EN
  assign w_rel_en     = rel_en;
  assign w_rel_offset = rel_offset;
`else
  assign w_rel_en     = 1'b0;
  assign w_rel_offset = '0;
`endif

  assign w_cmd = pick_cmd(load_en, call_en, ret_en, w_rel_en, count_en);

  // The stack decides on its own whether a push or pop is legal, and it sets
  // the sticky flags when one is not.
  pc_return_stack #(
    .W     (W),
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_cmd == CMD_CALL),
    .i_pop       (w_cmd == CMD_RET),
    .i_push_data (r_pc + W'(1)),
    .o_top_data  (w_top),
    .o_level     (stack_level),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  // All arithmetic wraps modulo 2^W through natural W-bit truncation.
  // A call to a full stack or a ret from an empty stack leaves PC unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= W'(PC_RESET);
    end else begin
      unique case (w_cmd)
        CMD_LOAD:  r_pc <= load_addr;
        CMD_CALL:  if (!w_full)  r_pc <= load_addr;
        CMD_RET:   if (!w_empty) r_pc <= w_top;
        CMD_REL:   r_pc <= r_pc + w_rel_offset;
        CMD_COUNT: r_pc <= r_pc + W'(1);
        default:   r_pc <= r_pc;
      endcase
    end
  end

  assign pc_value    = r_pc;
  assign pc_bus      = out_en ? r_pc : {W{1'bz}};
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer with W=4 and DEPTH=2. A directed
//   vector table covers reset, priority, call/ret and overflow/underflow.
//   Hand sequences cover counter wrap and reset in the middle of a call chain.
//   A randomized phase follows. Every cycle is also compared against a
//   reference model built from a PC integer and a queue acting as the
//   return stack.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int SW    = $clog2(DEPTH + 1);
  localparam int MOD   = 1 << W;

  logic          clk;
  logic          reset;
  logic          count_en;
  logic          load_en;
  logic [W-1:0]  load_addr;
  logic          call_en;
  logic          ret_en;
  logic          rel_en;
  logic [W-1:0]  rel_offset;
  logic          out_en;
  wire  [W-1:0]  pc_bus;
  logic [W-1:0]  pc_value;
  logic [SW-1:0] stack_level;
  logic          stack_full;
  logic          stack_empty;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_pc;
  int m_stack[$];
  bit m_ov;
  bit m_un;

  pc_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_en    (count_en),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .call_en     (call_en),
    .ret_en      (ret_en),
`ifdef PC_REL_BRANCH_EN
    .rel_en      (rel_en),
    .rel_offset  (rel_offset),
`endif
    .out_en      (out_en),
    .pc_bus      (pc_bus),
    .pc_value    (pc_value),
    .stack_level (stack_level),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Applies the model's rules for one clock edge. Only one command wins.
  task automatic model_step(input bit rst, cnt, ld, cl, rt, rl,
                            input int addr, off);
    if (rst) begin
      m_pc = 0; m_stack.delete(); m_ov = 0; m_un = 0;
    end else if (ld) begin
      m_pc = addr;
    end else if (cl) begin
      if (m_stack.size() == DEPTH) m_ov = 1;
      else begin
        m_stack.push_back((m_pc + 1) % MOD);
        m_pc = addr;
      end
    end else if (rt) begin
      if (m_stack.size() == 0) m_un = 1;
      else m_pc = m_stack.pop_back();
    end else if (rl) begin
      m_pc = (m_pc + off) % MOD;
    end else if (cnt) begin
      m_pc = (m_pc + 1) % MOD;
    end
  endtask

  task automatic compare_model(input string tag);
    bit bus_ok;
    check({tag, ".pc"},    int'(pc_value), m_pc);
    check({tag, ".level"}, int'(stack_level), m_stack.size());
    check({tag, ".full"},  int'(stack_full), int'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, int'(stack_empty), int'(m_stack.size() == 0));
    check({tag, ".ovf"},   int'(overflow), int'(m_ov));
    check({tag, ".unf"},   int'(underflow), int'(m_un));
    if (out_en) begin
      check({tag, ".bus"}, int'(pc_bus), m_pc);
    end else begin
      // An undriven bus may show as z or resolve to 0, depending on the
      // simulator. It must never carry a nonzero PC.
      bus_ok = (pc_bus === {W{1'bz}}) || (pc_bus === {W{1'b0}});
      check({tag, ".bus_off"}, int'(bus_ok), 1);
    end
  endtask

  // Drives one cycle of inputs at the falling edge. It samples 1 time unit
  // after the rising edge and compares against the model.
  task automatic step(input string tag, input bit rst, cnt, ld, cl, rt, rl, oe,
                      input int addr, input int off);
    @(negedge clk);
    reset = rst; count_en = cnt; load_en = ld; call_en = cl; ret_en = rt;
    rel_en = rl; out_en = oe; load_addr = W'(addr); rel_offset = W'(off);
    @(posedge clk);
    model_step(rst, cnt, ld, cl, rt, rl, addr, off);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    string name;
    bit    rst, cnt, ld, cl, rt, oe;
    int    addr;
    int    exp_pc, exp_lvl;
    bit    exp_ov, exp_un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input string n, input bit rst, cnt, ld, cl, rt, oe,
                             input int addr, pc, lvl, input bit ov, un);
    vec_t r;
    r.name = n; r.rst = rst; r.cnt = cnt; r.ld = ld; r.cl = cl; r.rt = rt;
    r.oe = oe; r.addr = addr; r.exp_pc = pc; r.exp_lvl = lvl;
    r.exp_ov = ov; r.exp_un = un;
    return r;
  endfunction

  initial begin
    reset = 1'b1; count_en = 0; load_en = 0; call_en = 0; ret_en = 0;
    rel_en = 0; out_en = 0; load_addr = '0; rel_offset = '0;
    m_pc = 0; m_ov = 0; m_un = 0;

    //            name         rst cnt ld cl rt oe addr  pc lvl ov un
    vecs.push_back(v("rst0",     1, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0));
    vecs.push_back(v("ld7",      0, 0, 1, 0, 0, 1,  7,   7, 0, 0, 0));
    vecs.push_back(v("rst_pc7",  1, 1, 1, 1, 0, 0,  5,   0, 0, 0, 0));
    vecs.push_back(v("ld3",      0, 0, 1, 0, 0, 0,  3,   3, 0, 0, 0));
    vecs.push_back(v("ld_prio",  0, 1, 1, 1, 0, 1,  9,   9, 0, 0, 0));
    vecs.push_back(v("ld2",      0, 0, 1, 0, 0, 0,  2,   2, 0, 0, 0));
    vecs.push_back(v("call8",    0, 0, 0, 1, 0, 1,  8,   8, 1, 0, 0));
    vecs.push_back(v("call12",   0, 0, 0, 1, 0, 0, 12,  12, 2, 0, 0));
    vecs.push_back(v("call_ful", 0, 0, 0, 1, 0, 1,  5,  12, 2, 1, 0));
    vecs.push_back(v("ret9",     0, 0, 0, 0, 1, 0,  0,   9, 1, 1, 0));
    vecs.push_back(v("ret3",     0, 0, 0, 0, 1, 1,  0,   3, 0, 1, 0));
    vecs.push_back(v("ret_emp",  0, 0, 0, 0, 1, 0,  0,   3, 0, 1, 1));
    vecs.push_back(v("hold",     0, 0, 0, 0, 0, 1,  0,   3, 0, 1, 1));
    vecs.push_back(v("rst_clr",  1, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0));
    vecs.push_back(v("call4",    0, 0, 0, 1, 0, 0,  4,   4, 1, 0, 0));
    vecs.push_back(v("call6",    0, 0, 0, 1, 0, 0,  6,   6, 2, 0, 0));
    vecs.push_back(v("rst_mid",  1, 0, 0, 0, 1, 0,  0,   0, 0, 0, 0));
    vecs.push_back(v("ret_unf",  0, 0, 0, 0, 1, 1,  0,   0, 0, 0, 1));
    vecs.push_back(v("ld15",     0, 0, 1, 0, 0, 0, 15,  15, 0, 0, 1));
    vecs.push_back(v("call_wr",  0, 0, 0, 1, 0, 0, 10,  10, 1, 0, 1));
    vecs.push_back(v("ret_cnt",  0, 1, 0, 0, 1, 1,  0,   0, 0, 0, 1));

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].cnt, vecs[i].ld, vecs[i].cl,
           vecs[i].rt, 1'b0, vecs[i].oe, vecs[i].addr, 0);
      check({vecs[i].name, ".tbl_pc"},  int'(pc_value),    vecs[i].exp_pc);
      check({vecs[i].name, ".tbl_lvl"}, int'(stack_level), vecs[i].exp_lvl);
      check({vecs[i].name, ".tbl_ovf"}, int'(overflow),    int'(vecs[i].exp_ov));
      check({vecs[i].name, ".tbl_unf"}, int'(underflow),   int'(vecs[i].exp_un));
    end

    // Counter wrap: 17 increments starting from 0 visit 1..15, 0, 1.
    step("cnt_rst", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      step("cnt", 0, 1, 0, 0, 0, 0, 1, 0, 0);
      check("cnt_seq", int'(pc_value), k % 16);
      check("cnt_bus", int'(pc_bus), k % 16);
    end

`ifdef PC_REL_BRANCH_EN
    step("rel_ld2", 0, 0, 1, 0, 0, 0, 1, 2, 0);
    step("rel_m2",  0, 0, 0, 0, 0, 1, 1, 0, 14);
    check("rel_back", int'(pc_value), 0);
    step("rel_ld14", 0, 0, 1, 0, 0, 0, 1, 14, 0);
    step("rel_p3",  0, 0, 0, 0, 0, 1, 1, 0, 3);
    check("rel_wrap", int'(pc_value), 1);
    step("rel_cnt", 0, 1, 0, 0, 0, 1, 1, 0, 5);
    check("rel_prio", int'(pc_value), 6);
`endif

    // Randomized phase. Reset is rare, so call chains build up and hit the
    // overflow and underflow corners.
    for (int n = 0; n < 400; n++) begin
      bit rl;
`ifdef PC_REL_BRANCH_EN
      rl = ($urandom_range(0, 3) == 0);
`else
      rl = 1'b0;
`endif
      step("rnd", ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), rl, $urandom_range(0, 1),
           $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
